// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normalizer FSM states, status flag payload,
// default field widths, exponent bias and raw-sum bit positions.
package fpu_pkg;

    localparam int unsigned EXP_WIDTH_DEF  = 8;
    localparam int unsigned MANT_WIDTH_DEF = 23;
    localparam int unsigned EXP_BIAS       = (1 << (EXP_WIDTH_DEF - 1)) - 1;

    // Raw-sum layout: carry, hidden, fraction, guard, round, sticky
    localparam int unsigned SUM_WIDTH  = MANT_WIDTH_DEF + 5;
    localparam int unsigned CARRY_BIT  = MANT_WIDTH_DEF + 4;
    localparam int unsigned HIDDEN_BIT = MANT_WIDTH_DEF + 3;
    localparam int unsigned GUARD_BIT  = 2;

    // Same positions for an arbitrary fraction width
    function automatic int unsigned sum_width(input int unsigned mant_width);
        return mant_width + 5;
    endfunction

    function automatic int unsigned carry_bit(input int unsigned mant_width);
        return mant_width + 4;
    endfunction

    function automatic int unsigned hidden_bit(input int unsigned mant_width);
        return mant_width + 3;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

endpackage

// File: rtl/lead_zero_cnt.sv
// Leading-zero counter (combinational priority encoder).
// Ports:
//   vec      - bits to scan, MSB first
//   count    - number of zeros above the most significant one (WIDTH if none)
//   all_zero - vec has no bit set
module lead_zero_cnt #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CW-1:0]    count,
    output logic             all_zero
);

    // Scan upward so the most significant set bit is the last to win
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
        all_zero = ~|vec;
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-addition normalizer and round-to-nearest-even packer for the FPU adder.
// Ports:
//   clk, arst_n                    - clock, asynchronous active-low reset
//   in_valid/in_ready              - upstream handshake for one raw sum
//   in_sign, in_exp, in_mant       - adder sign, biased common exponent, raw sum
//   out_valid/out_ready            - downstream handshake, result held until taken
//   out_result                     - {sign, exponent, fraction}
//   out_overflow/underflow/inexact - status flags accompanying out_result
module fp_normalize_round
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = EXP_WIDTH_DEF,
    parameter int unsigned MANT_WIDTH = MANT_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sign,
    input  logic [EXP_WIDTH-1:0]              in_exp,
    input  logic [MANT_WIDTH+4:0]             in_mant,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP_WIDTH+MANT_WIDTH:0]     out_result,
    output logic                              out_overflow,
    output logic                              out_underflow,
    output logic                              out_inexact
);

    localparam int unsigned SW  = sum_width(MANT_WIDTH);
    localparam int unsigned CB  = carry_bit(MANT_WIDTH);
    localparam int unsigned HB  = hidden_bit(MANT_WIDTH);
    localparam int unsigned GB  = GUARD_BIT;
    localparam int unsigned XW  = EXP_WIDTH + 2;
    localparam int unsigned LZW = $clog2(MANT_WIDTH + 5);
    localparam int unsigned RW  = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int unsigned PW  = MANT_WIDTH + 2;

    state_t                 state_q, state_n;
    logic                   sign_q, sign_n;
    logic signed [XW-1:0]   exp_q, exp_n;
    logic [SW-1:0]          mant_q, mant_n;
    logic                   zero_q, zero_n;
    logic                   in_ready_q, in_ready_n;
    logic                   out_valid_q, out_valid_n;
    logic [RW-1:0]          result_q, result_n;
    fp_flags_t              flags_q, flags_n;

    logic [LZW-1:0]         lz_cnt;
    logic                   lz_all_zero;

    logic                   round_up;
    logic [PW-1:0]          rnd_sum;
    logic signed [XW-1:0]   exp_f;
    logic [MANT_WIDTH-1:0]  frac_f;

    lead_zero_cnt #(
        .WIDTH (SW - 1),
        .CW    (LZW)
    ) u_lzc (
        .vec      (mant_q[CB-1:0]),
        .count    (lz_cnt),
        .all_zero (lz_all_zero)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_n;
            sign_q      <= sign_n;
            exp_q       <= exp_n;
            mant_q      <= mant_n;
            zero_q      <= zero_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            result_q    <= result_n;
            flags_q     <= flags_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n     = state_q;
        sign_n      = sign_q;
        exp_n       = exp_q;
        mant_n      = mant_q;
        zero_n      = zero_q;
        out_valid_n = out_valid_q;
        result_n    = result_q;
        flags_n     = flags_q;

        // RNE on the normalized sum: lsb at GB+1, sticky-ored round/sticky below guard
        round_up = mant_q[GB] & (mant_q[GB-1] | mant_q[GB-2] | mant_q[GB+1]);
        rnd_sum  = {1'b0, mant_q[HB:GB+1]} + PW'(round_up);
        // Carry-out means the significand rounded up to 2.0
        exp_f    = rnd_sum[PW-1] ? exp_q + $signed(XW'(1)) : exp_q;
        frac_f   = rnd_sum[PW-1] ? rnd_sum[MANT_WIDTH:1] : rnd_sum[MANT_WIDTH-1:0];

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_n  = in_sign;
                    exp_n   = $signed({2'b00, in_exp});
                    mant_n  = in_mant;
                    zero_n  = 1'b0;
                    state_n = ST_NORM;
                end
            end
            ST_NORM: begin
                if (mant_q[CB]) begin
                    // Fold the bit shifted out into sticky
                    mant_n = {1'b0, mant_q[SW-1:2], mant_q[1] | mant_q[0]};
                    exp_n  = exp_q + $signed(XW'(1));
                end else if (lz_all_zero) begin
                    zero_n = 1'b1;
                end else begin
                    mant_n = mant_q << lz_cnt;
                    exp_n  = exp_q - $signed(XW'(lz_cnt));
                end
                state_n = ST_ROUND;
            end
            ST_ROUND: begin
                flags_n = '0;
                if (zero_q) begin
                    result_n = '0;
                end else if (exp_f >= $signed(XW'((1 << EXP_WIDTH) - 1))) begin
                    result_n          = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    flags_n.overflow  = 1'b1;
                    flags_n.inexact   = 1'b1;
                end else if (exp_f <= $signed(XW'(0))) begin
                    result_n          = {sign_q, {(RW-1){1'b0}}};
                    flags_n.underflow = 1'b1;
                    flags_n.inexact   = 1'b1;
                end else begin
                    result_n        = {sign_q, exp_f[EXP_WIDTH-1:0], frac_f};
                    flags_n.inexact = |mant_q[GB:0];
                end
                out_valid_n = 1'b1;
                state_n     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        in_ready_n = (state_n == ST_IDLE);
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_overflow  = flags_q.overflow;
    assign out_underflow = flags_q.underflow;
    assign out_inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed corner cases plus random sums,
// compared against an arithmetic model of normalize + round-to-nearest-even.
module tb_fp_normalize_round;

    localparam int unsigned EW = 8;
    localparam int unsigned MW = 23;

    logic              clk;
    logic              arst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EW-1:0]     in_exp;
    logic [MW+4:0]     in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [EW+MW:0]    out_result;
    logic              out_overflow;
    logic              out_underflow;
    logic              out_inexact;

    int n_checks = 0;
    int n_errors = 0;

    fp_normalize_round #(
        .EXP_WIDTH  (EW),
        .MANT_WIDTH (MW)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Returns {overflow, underflow, inexact, result[31:0]}
    function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [27:0] m);
        int unsigned n;
        int unsigned keep;
        int unsigned rem;
        int          ex;
        logic        up;
        if (m == 28'd0) return 35'd0;
        n  = m;
        ex = int'(e);
        // Bring the value into [2^26, 2^27): one leading one at the hidden position
        if (n >= 32'h0800_0000) begin
            n  = (n >> 1) | (n & 1);
            ex = ex + 1;
        end else begin
            while (n < 32'h0400_0000) begin
                n  = n * 2;
                ex = ex - 1;
            end
        end
        keep = n >> 3;
        rem  = n & 7;
        up   = (rem > 4) || (rem == 4 && (keep % 2) == 1);
        keep = keep + (up ? 1 : 0);
        if (keep == 32'h0100_0000) begin
            keep = keep / 2;
            ex   = ex + 1;
        end
        if (ex >= 255) return {1'b1, 1'b0, 1'b1, s, 8'hFF, 23'd0};
        if (ex <= 0)   return {1'b0, 1'b1, 1'b1, s, 31'd0};
        return {1'b0, 1'b0, (rem != 0), s, 8'(ex), 23'(keep)};
    endfunction

    // One full transaction; hold = cycles out_ready stays low after out_valid
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] m, input int hold);
        logic [34:0] want;
        logic [31:0] first;
        int          waitc;
        int          lat;
        want = model(s, e, m);
        @(negedge clk);
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check({tag, "_in_ready_wait"}, 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy_in_ready"}, 64'(in_ready), 64'(0));
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check({tag, "_out_valid_wait"}, 64'(out_valid), 64'(1));
            out_ready = 1'b1;
            return;
        end
        check({tag, "_latency"}, 64'(lat), 64'(3));
        check({tag, "_result"}, 64'(out_result), 64'(want[31:0]));
        check({tag, "_flags"}, 64'({out_overflow, out_underflow, out_inexact}), 64'(want[34:32]));
        first = out_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_result"}, 64'(out_result), 64'(first));
            check({tag, "_hold_valid"}, 64'({out_valid, in_ready}), 64'(2'b10));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [31:0] mask;
        int          k;
        logic        seen;
        arst_n    = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(out_result), 64'(0));
        check("reset_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(0));
        arst_n = 1'b1;

        // Directed corners (model also re-derives each value)
        run_op("one_plus_one", 1'b0, 8'd127, 28'h800_0000, 0);
        check("one_plus_one_value", 64'(out_result), 64'h4000_0000);
        run_op("cancel", 1'b0, 8'd127, 28'h080_0000, 1);
        check("cancel_value", 64'(out_result), 64'h3E00_0000);
        run_op("tie_even", 1'b0, 8'd127, 28'h400_0004, 0);
        check("tie_even_value", 64'({out_inexact, out_result}), 64'h1_3F80_0000);
        run_op("tie_odd", 1'b0, 8'd127, 28'h400_000C, 0);
        check("tie_odd_value", 64'(out_result), 64'h3F80_0002);
        run_op("rnd_carry", 1'b0, 8'd127, 28'h7FF_FFFC, 0);
        check("rnd_carry_value", 64'(out_result), 64'h4000_0000);
        run_op("overflow", 1'b0, 8'd254, 28'h800_0000, 0);
        check("overflow_value", 64'({out_overflow, out_result}), 64'h1_7F80_0000);
        run_op("underflow", 1'b1, 8'd2, 28'h080_0000, 0);
        check("underflow_value", 64'({out_underflow, out_result}), 64'h1_8000_0000);
        run_op("zero", 1'b1, 8'd100, 28'h000_0000, 0);
        check("zero_value", 64'({out_overflow, out_underflow, out_inexact, out_result}), 64'h0);
        run_op("backpressure", 1'b0, 8'd130, 28'h5A5_A5A7, 5);

        // Reset in the middle of an operation drops it
        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_mant  = 28'h400_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        arst_n   = 1'b0;
        #1;
        check("midreset_async", 64'({out_valid, in_ready}), 64'(2'b01));
        @(negedge clk);
        arst_n = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midreset_no_output", 64'(seen), 64'(0));
        check("midreset_in_ready", 64'(in_ready), 64'(1));

        // Random sums with a spread of leading-zero counts and exponents
        for (int t = 0; t < 300; t++) begin
            k    = $urandom_range(0, 28);
            mask = (k >= 28) ? 32'h0FFF_FFFF : ((32'd1 << k) - 32'd1);
            run_op("rand", 1'($urandom), 8'($urandom_range(0, 255)),
                   28'($urandom & mask), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Post-addition normalizer and rounder for the FPU adder datapath. Takes the raw signed-magnitude mantissa sum and the common (larger) exponent produced by the alignment stage and mantissa adder. Normalizes via leading-zero count or single right shift, rounds to nearest-even, and packs an IEEE-754-style result with status flags. A ready/valid handshake on both sides lets it stall against the downstream writeback stage.

## Interface
- EXP_WIDTH, 8, exponent field width
- MANT_WIDTH, 23, stored fraction width (hidden bit excluded)
- clk  input  1  clock, rising edge
- arst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream sum valid
- in_ready  output  1  block can accept a sum
- in_sign  input  1  result sign from the adder
- in_exp  input  EXP_WIDTH  common exponent, biased
- in_mant  input  MANT_WIDTH+5  raw sum: [MANT_WIDTH+4] carry, [MANT_WIDTH+3] hidden, [MANT_WIDTH+2:3] fraction, [2] guard, [1] round, [0] sticky
- out_valid  output  1  packed result valid
- out_ready  input  1  downstream accepts result
- out_result  output  1+EXP_WIDTH+MANT_WIDTH  {sign, exponent, fraction}
- out_overflow  output  1  result saturated to infinity
- out_underflow  output  1  result flushed to zero
- out_inexact  output  1  guard/round/sticky nonzero, or overflow/underflow

## Operation
- Upstream guarantees finite operands; NaN/infinity bypass this block.
- FSM states: IDLE -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, register sign, exp (zero-extended to signed EXP_WIDTH+2), and mant. Go to NORM.
- NORM, carry=1: shift right 1, new sticky = old round | old sticky, exp+1.
- NORM, carry=0 and mant=0: exact zero. Result +0, all flags 0.
- NORM, otherwise: shift left by lz (count of leading zeros below carry), exp -= lz.
- NORM exits to ROUND in all cases; a zero result skips the arithmetic.
- ROUND: lsb = bit 3, g = bit 2, rs = bit1|bit0. round_up = g & (rs | lsb).
- ROUND: add round_up to {hidden,fraction}. On carry-out (value 2.0), shift right 1 and exp+1.
- Final exp >= 2^EXP_WIDTH-1: overflow. Result {sign, all-ones, 0}, overflow=1, inexact=1.
- Final exp <= 0: flush to zero. Result {sign, 0, 0}, underflow=1, inexact=1. Denormals are not produced.
- Otherwise inexact = g|r|s, evaluated before rounding.
- DONE: out_valid=1. out_result and flags are held stable until out_ready, then go to IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, all flags 0.
- Latency: out_valid rises on the 3rd rising edge after the accepting edge.
- in_ready=0 in NORM, ROUND, and DONE. Minimum initiation interval is 4 cycles.
- out_ready is ignored unless out_valid=1.
- out_ready held high gives a single-cycle DONE.
- in_valid arriving while busy is not accepted. Upstream must hold it until in_ready.
- Reset asserted mid-operation drops the in-flight sum with no output. Outputs take reset values immediately (asynchronous).

## Structure
- Shared package fpu_pkg: state enum, exponent bias, field index constants (CARRY_BIT, HIDDEN_BIT, GUARD_BIT), and the sum width MANT_WIDTH+5.
- Sub-module lead_zero_cnt: combinational priority encoder over the MANT_WIDTH+4 bits below carry. Output width $clog2(MANT_WIDTH+5).
- Sub-module lead_zero_cnt has an all-zero flag output.

## Test plan
- 1.0+1.0: sign 0, exp 127, mant bit27=1 only -> result 0x40000000, flags 0, out_valid 3 cycles after accept.
- Cancellation: exp 127, mant bit23=1 only -> lz 3 -> 0x3E000000.
- RNE tie, lsb=0: exp 127, hidden=1, fraction 0, guard=1 -> 0x3F800000, inexact=1. Same input with fraction lsb=1 -> 0x3F800002.
- Round carry-out: hidden=1, fraction all ones, guard=1, exp 127 -> 0x40000000.
- Overflow/underflow: exp 254 with carry=1 -> 0x7F800000, overflow=1. Exp 2 with bit23=1 only (lz 3) -> 0x00000000 with sign, underflow=1. Mant 0 -> 0x00000000, flags 0.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> result stable, in_ready=0. Pulse arst_n in NORM -> out_valid never rises, in_ready=1 after release.
